// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and its downstream counter stage:
// FSM state encoding and the clock-to-tick divider derivation.
package stopwatch_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    // Clocks per tick; returns 0 for a zero tick rate so the caller's range check trips.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        if (tick_hz == 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw key conditioning: 2-flop synchronizer, stability-window debouncer and
// a one-cycle press pulse when the debounced level rises.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    if (DB_CYCLES < 1) begin : g_db_check
        $error("btn_debounce: DB_CYCLES must be at least 1");
    end

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Level follows the synchronized key only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear keys drive an IDLE/RUN/PAUSE FSM
// and a prescaler that issues count ticks and clear requests to the BCD counter stage.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ   = 10,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_ss,
    input  logic               btn_clr,
    output logic               tick,
    output logic               clr,
    output logic               running,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_div_check
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer of at least 2");
    end

    logic             ss_ev;
    logic             clr_ev;
    sw_state_e        state_q;
    sw_state_e        state_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick_d;
    logic             clr_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_ss),
        .press (ss_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .press (clr_ev)
    );

    // State, prescaler and all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            tick    <= 1'b0;
            clr     <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick    <= tick_d;
            clr     <= clr_d;
            running <= (state_d == RUN);
        end
    end

    // Clear beats start/stop and also swallows a tick due on the same clock.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        if (clr_ev) begin
            state_d = IDLE;
            pre_d   = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    pre_d = '0;
                    if (ss_ev) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pre_q == PRE_W'(DIV - 1)) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                    if (ss_ev) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (ss_ev) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
